// File: rtl/gpr_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_scoreboard
//  Description : General-purpose register file with a per-register busy
//                (pending-write) scoreboard. After reset a CLEAR sequence
//                zeroes one register per cycle. The ports become usable only
//                once ready is high.
//                Build option: define GPR_BYPASS_EN so that a same-cycle
//                write is forwarded to the read ports.
//  Revision    : 1.0  initial release
// ============================================================================
module gpr_scoreboard #(
    parameter  int XLEN     = 32,
    parameter  int NREG     = 32,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ready,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rrs1,
    output logic [XLEN-1:0] rrs2,
    output logic            busy1,
    output logic            busy2,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] rrd,
    input  logic            we,
    input  logic            alloc_en,
    input  logic [AW-1:0]   alloc_rd
);

    localparam logic [0:0]    c_ST_CLEAR = 1'b0;
    localparam logic [0:0]    c_ST_RUN   = 1'b1;
    localparam logic [AW-1:0] c_IDX_LAST = AW'(NREG - 1);

    logic [0:0]      r_state;
    logic [AW-1:0]   r_idx;
    logic [XLEN-1:0] r_mem [NREG];
    logic [NREG-1:0] r_busy;

    logic w_run;
    logic w_rd_ok;
    logic w_alloc_ok;
    logic w_wr_hit;
    logic w_alloc_hit;
    logic w_rs1_zero;
    logic w_rs2_zero;

    // Register 0 is excluded from writes and allocations when it is hardwired.
    assign w_run       = (r_state == c_ST_RUN);
    assign w_rd_ok     = (ZERO_REG == 0) || (rd != '0);
    assign w_alloc_ok  = (ZERO_REG == 0) || (alloc_rd != '0);
    assign w_wr_hit    = we && w_run && w_rd_ok;
    assign w_alloc_hit = alloc_en && w_run && w_alloc_ok;
    assign w_rs1_zero  = (ZERO_REG != 0) && (rs1 == '0);
    assign w_rs2_zero  = (ZERO_REG != 0) && (rs2 == '0);
    assign ready       = w_run;

    // Control FSM: walk idx through every register, then enter RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_CLEAR;
            r_idx   <= '0;
        end else if (r_state == c_ST_CLEAR) begin
            if (r_idx == c_IDX_LAST) begin
                r_state <= c_ST_RUN;
                r_idx   <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Storage: zeroed one entry per cycle during CLEAR, written in RUN.
    always_ff @(posedge clk) begin
        if (r_state == c_ST_CLEAR) begin
            r_mem[r_idx] <= '0;
        end else if (!rst && w_wr_hit) begin
            r_mem[rd] <= rrd;
        end
    end

    // Busy bits: a write clears, an allocation sets; the allocation is
    // assigned last so it wins when both target the same register.
    always_ff @(posedge clk) begin
        if (r_state == c_ST_CLEAR) begin
            r_busy[r_idx] <= 1'b0;
        end else if (!rst) begin
            if (w_wr_hit) begin
                r_busy[rd] <= 1'b0;
            end
            if (w_alloc_hit) begin
                r_busy[alloc_rd] <= 1'b1;
            end
        end
    end

    // Read ports: all zero until ready; a write landing this cycle hides
    // the busy bit, and optionally forwards its data.
    always_comb begin
        rrs1  = '0;
        rrs2  = '0;
        busy1 = 1'b0;
        busy2 = 1'b0;
        if (w_run) begin
`ifdef GPR_BYPASS_EN
            rrs1 = (w_wr_hit && (rd == rs1)) ? rrd : r_mem[rs1];
            rrs2 = (w_wr_hit && (rd == rs2)) ? rrd : r_mem[rs2];
`else
            rrs1 = r_mem[rs1];
            rrs2 = r_mem[rs2];
`endif
            if (w_rs1_zero) begin
                rrs1 = '0;
            end
            if (w_rs2_zero) begin
                rrs2 = '0;
            end
            busy1 = r_busy[rs1] && !(w_wr_hit && (rd == rs1)) && !w_rs1_zero;
            busy2 = r_busy[rs2] && !(w_wr_hit && (rd == rs2)) && !w_rs2_zero;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpr_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpr_scoreboard
//  Description : Self-checking bench for gpr_scoreboard (default parameters).
//                Directed scenarios followed by random traffic, all compared
//                against a register-array reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gpr_scoreboard;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            ready;
    logic [AW-1:0]   rs1, rs2, rd, alloc_rd;
    logic [XLEN-1:0] rrs1, rrs2, rrd;
    logic            busy1, busy2, we, alloc_en;

    int total = 0;
    int bad   = 0;

    // Reference model: register contents, pending flags, and the number of
    // edges still needed before the register file becomes usable.
    logic [XLEN-1:0] m_mem  [NREG];
    bit              m_busy [NREG];
    int              m_clear_left;

    always #5 clk = ~clk;

    gpr_scoreboard #(
        .XLEN     (XLEN),
        .NREG     (NREG),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .rs1      (rs1),
        .rs2      (rs2),
        .rrs1     (rrs1),
        .rrs2     (rrs2),
        .busy1    (busy1),
        .busy2    (busy2),
        .rd       (rd),
        .rrd      (rrd),
        .we       (we),
        .alloc_en (alloc_en),
        .alloc_rd (alloc_rd)
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit writable(input logic [AW-1:0] a);
        return a != '0;
    endfunction

    function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] rs);
        if (m_clear_left != 0) return '0;
`ifdef GPR_BYPASS_EN
        if (we && writable(rd) && rd == rs) return rrd;
`endif
        return m_mem[rs];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] rs);
        if (m_clear_left != 0) return 1'b0;
        return m_busy[rs] && !(we && writable(rd) && rd == rs);
    endfunction

    // One clock: check outputs on the falling edge, then advance the model
    // on the rising edge, then leave time for the stimulus to change.
    task automatic step();
        @(negedge clk);
        chk("ready", XLEN'(ready), XLEN'(m_clear_left == 0));
        chk("rrs1",  rrs1, exp_read(rs1));
        chk("rrs2",  rrs2, exp_read(rs2));
        chk("busy1", XLEN'(busy1), XLEN'(exp_busy(rs1)));
        chk("busy2", XLEN'(busy2), XLEN'(exp_busy(rs2)));
        @(posedge clk);
        if (rst) begin
            m_clear_left = NREG;
        end else if (m_clear_left != 0) begin
            m_clear_left--;
            if (m_clear_left == 0) begin
                for (int i = 0; i < NREG; i++) begin
                    m_mem[i]  = '0;
                    m_busy[i] = 1'b0;
                end
            end
        end else begin
            if (we && writable(rd)) begin
                m_mem[rd]  = rrd;
                m_busy[rd] = 1'b0;
            end
            if (alloc_en && writable(alloc_rd)) begin
                m_busy[alloc_rd] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        we       = 1'b0;
        alloc_en = 1'b0;
        rd       = '0;
        alloc_rd = '0;
        rrd      = '0;
    endtask

    initial begin
        rst = 1'b1;
        rs1 = '0;
        rs2 = '0;
        idle_inputs();
        m_clear_left = NREG;
        @(posedge clk);
        #1;

        // Reset held, then released: 32 cycles of ready=0 with zero reads.
        step();
        rst = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            rs1 = AW'($urandom);
            rs2 = AW'($urandom);
            step();
        end
        #3;
        chk("ready_after_clear", XLEN'(ready), 32'd1);
        step();

        // Reset restart at clear cycle 10; writes during CLEAR are ignored.
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        we = 1'b1; rd = 5'd9; rrd = 32'h0000_0123;
        alloc_en = 1'b1; alloc_rd = 5'd9;
        rs1 = 5'd9;
        repeat (31) step();
        #3;
        chk("restart_ready_c31", XLEN'(ready), 32'd0);
        step();
        idle_inputs();
        #3;
        chk("restart_ready_c32", XLEN'(ready), 32'd1);
        chk("clear_write_ignored", rrs1, 32'd0);
        chk("clear_alloc_ignored", XLEN'(busy1), 32'd0);
        step();

        // Scoreboard: allocate x5, then write it.
        alloc_en = 1'b1; alloc_rd = 5'd5;
        step();
        alloc_en = 1'b0; rs1 = 5'd5;
        #3;
        chk("alloc_busy", XLEN'(busy1), 32'd1);
        step();
        we = 1'b1; rd = 5'd5; rrd = 32'hDEAD_BEEF;
        #3;
        chk("write_hides_busy", XLEN'(busy1), 32'd0);
        step();
        idle_inputs();
        #3;
        chk("write_data", rrs1, 32'hDEAD_BEEF);
        chk("write_busy_cleared", XLEN'(busy1), 32'd0);
        step();

        // Collision on x7: data stored, allocation wins.
        we = 1'b1; rd = 5'd7; rrd = 32'h0000_0012;
        alloc_en = 1'b1; alloc_rd = 5'd7;
        step();
        idle_inputs();
        rs1 = 5'd7;
        #3;
        chk("collision_busy", XLEN'(busy1), 32'd1);
        chk("collision_data", rrs1, 32'h0000_0012);
        step();

        // Bypass behaviour on x3.
        we = 1'b1; rd = 5'd3; rrd = 32'h1111_1111;
        step();
        rs2 = 5'd3; rrd = 32'hA5A5_A5A5;
        #3;
`ifdef GPR_BYPASS_EN
        chk("bypass_same_cycle", rrs2, 32'hA5A5_A5A5);
`else
        chk("no_bypass_old", rrs2, 32'h1111_1111);
`endif
        step();
        idle_inputs();
        #3;
        chk("bypass_next_cycle", rrs2, 32'hA5A5_A5A5);
        step();

        // Register 0 is hardwired: write and allocation are dropped.
        we = 1'b1; rd = 5'd0; rrd = 32'hFFFF_FFFF;
        alloc_en = 1'b1; alloc_rd = 5'd0;
        rs1 = 5'd0;
        #3;
        chk("x0_read_same", rrs1, 32'd0);
        step();
        idle_inputs();
        #3;
        chk("x0_read", rrs1, 32'd0);
        chk("x0_busy", XLEN'(busy1), 32'd0);
        step();

        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(199) == 0);
            we       = $urandom_range(1);
            alloc_en = $urandom_range(1);
            rd       = ($urandom_range(3) == 0) ? AW'($urandom_range(3)) : AW'($urandom);
            alloc_rd = ($urandom_range(3) == 0) ? rd : AW'($urandom);
            rrd      = $urandom;
            rs1      = ($urandom_range(2) == 0) ? rd : AW'($urandom);
            rs2      = ($urandom_range(2) == 0) ? alloc_rd : AW'($urandom);
            step();
        end
        rst = 1'b0;
        idle_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
